// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Single-outstanding word memory responder. It accepts one
//             load/store request, waits a fixed LATENCY, commits the access
//             against internal storage and holds the response until the
//             initiator consumes it. Faulting accesses never touch storage.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] done_count
);

    localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The accept edge and the WAIT->RESP edge together account for two
    // cycles of latency, so the counter only covers the remainder.
    localparam logic [3:0] c_wait_load = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q,      state_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic        write_q,      write_d;
    logic [31:0] addr_q,       addr_d;
    logic [31:0] wdata_q,      wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q,   resp_err_d;
    logic [15:0] done_count_q, done_count_d;

    logic [31:0] mem_q [DEPTH];

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_src_write;
    logic [31:0]      w_src_addr;
    logic [31:0]      w_src_wdata;
    logic             w_fault;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd_word;
    logic             w_mem_we;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign done_count = done_count_q;

    assign w_accept = req_valid & req_ready;

    // Select the request that commits on this edge: with LATENCY==1 the
    // commit edge is the accept edge, so the live request inputs are used;
    // otherwise the captured request is used.
    always_comb begin
        w_src_write = write_q;
        w_src_addr  = addr_q;
        w_src_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            w_src_write = req_write;
            w_src_addr  = req_addr;
            w_src_wdata = req_wdata;
        end
    end

    // Fault on misalignment or a word index beyond the storage array.
    assign w_fault   = (w_src_addr[1:0] != 2'b00) ||
                       ({2'b00, w_src_addr[31:2]} >= 32'(DEPTH));
    assign w_idx     = w_src_addr[IDX_W+1:2];
    assign w_rd_word = mem_q[w_idx];

    assign w_enter_resp = ((state_q == ST_IDLE) && w_accept && (LATENCY == 1)) ||
                          ((state_q == ST_WAIT) && (cnt_q == 4'd0));

    // Reset blocks the commit so an abandoned store never lands.
    assign w_mem_we = w_enter_resp & w_src_write & ~w_fault & ~reset;

    // Next-state and next-output computation for the request/response FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        done_count_d = done_count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = c_wait_load;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                    done_count_d = done_count_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_enter_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = w_fault;
            resp_rdata_d = (!w_fault && !w_src_write) ? w_rd_word : 32'd0;
        end
    end

    // Control and response registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            done_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            done_count_q <= done_count_d;
        end
    end

    // Word storage: written only at a non-faulting store commit, never reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_idx] <= w_src_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Scoreboard bench for mem_responder (LATENCY=2 and LATENCY=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    // LATENCY=2 instance
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] done_count;

    // LATENCY=1 instance
    logic        clk1 = 1'b0;
    logic        reset1 = 1'b1;
    logic        req_valid1 = 1'b0;
    logic        req_ready1;
    logic        req_write1 = 1'b0;
    logic [31:0] req_addr1 = 32'd0;
    logic [31:0] req_wdata1 = 32'd0;
    logic        resp_valid1;
    logic        resp_ready1 = 1'b0;
    logic [31:0] resp_rdata1;
    logic        resp_err1;
    logic [15:0] done_count1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] done_exp = 16'd0;
    logic [31:0] model_mem [64];
    exp_t        sb [$];
    exp_t        sb1 [$];

    always #5 clk  = ~clk;
    always #1 clk1 = ~clk1;

    mem_responder #(.DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .done_count(done_count)
    );

    mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk1), .reset(reset1),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1), .done_count(done_count1)
    );

    // Expected response for a request, from the bench's own memory model.
    function automatic exp_t model_access(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic flt;
        flt = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
        e.err   = flt;
        e.rdata = 32'd0;
        if (!flt) begin
            if (w) model_mem[a[7:2]] = d;
            else   e.rdata = model_mem[a[7:2]];
        end
        return e;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e.rdata = 'x;
        e.err   = 1'bx;
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction

    // Drive one request, wait for the accept edge (pushing the expectation),
    // then wait for resp_valid. lat counts edges from the accept edge (=1).
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic keep_valid, output int lat,
                       output logic [31:0] rd, output logic er);
        logic ok;
        ok  = 1'b0;
        lat = -1;
        @(negedge clk);
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            sb.push_back(model_access(w, a, d));
            #1;
            if (!keep_valid) req_valid = 1'b0;
            for (int e = 1; e <= 20; e++) begin
                if (resp_valid) begin lat = e; break; end
                @(posedge clk); #1;
            end
        end else begin
            req_valid = 1'b0;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    // Consume the pending response.
    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        done_exp = done_exp + 16'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        done_exp = 16'd0;
        n_checks++; if (req_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
        n_checks++; if (resp_err !== 1'b0)    begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
        n_checks++; if (done_count !== 16'd0) begin n_fail++; $display("FAIL rst_done_count: got %0d want 0", done_count); end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er; exp_t e;
        txn(1'b1, 32'h64, 32'h7, 1'b0, lat, rd, er);
        e = pop_exp();
        n_checks++; if (lat !== 2)     begin n_fail++; $display("FAIL sl_store_latency: got %0d want 2", lat); end
        n_checks++; if (er !== e.err)  begin n_fail++; $display("FAIL sl_store_err: got %b want %b", er, e.err); end
        handshake();
        txn(1'b0, 32'h64, 32'h0, 1'b0, lat, rd, er);
        e = pop_exp();
        n_checks++; if (lat !== 2)       begin n_fail++; $display("FAIL sl_load_latency: got %0d want 2", lat); end
        n_checks++; if (rd !== e.rdata)  begin n_fail++; $display("FAIL sl_load_rdata: got %h want %h", rd, e.rdata); end
        n_checks++; if (er !== e.err)    begin n_fail++; $display("FAIL sl_load_err: got %b want %b", er, e.err); end
        handshake();
        n_checks++; if (done_count !== done_exp) begin n_fail++; $display("FAIL sl_done_count: got %0d want %0d", done_count, done_exp); end
        n_checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin n_fail++; $display("FAIL sl_resp_clear: got valid=%b rdata=%h want 0/0", resp_valid, resp_rdata); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd; logic er; exp_t e;
        txn(1'b1, 32'h60, 32'h12345678, 1'b0, lat, rd, er);
        e = pop_exp();
        handshake();
        txn(1'b1, 32'h62, 32'hDEADBEEF, 1'b0, lat, rd, er);
        e = pop_exp();
        n_checks++; if (er !== e.err)   begin n_fail++; $display("FAIL mis_err: got %b want %b", er, e.err); end
        n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL mis_rdata: got %h want %h", rd, e.rdata); end
        handshake();
        txn(1'b0, 32'h60, 32'h0, 1'b0, lat, rd, er);
        e = pop_exp();
        n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL mis_load_0x60: got %h want %h", rd, e.rdata); end
        n_checks++; if (er !== e.err)   begin n_fail++; $display("FAIL mis_load_err: got %b want %b", er, e.err); end
        handshake();
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er; exp_t e;
        txn(1'b0, 32'h100, 32'h0, 1'b0, lat, rd, er);
        e = pop_exp();
        n_checks++; if (er !== e.err)   begin n_fail++; $display("FAIL oor_err: got %b want %b", er, e.err); end
        n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL oor_rdata: got %h want %h", rd, e.rdata); end
        handshake();
        n_checks++; if (done_count !== done_exp) begin n_fail++; $display("FAIL oor_done_count: got %0d want %0d", done_count, done_exp); end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er; exp_t e;
        txn(1'b1, 32'h20, 32'h11223344, 1'b0, lat, rd, er);
        e = pop_exp();
        handshake();
        // Load with req_valid held; during the stall, present a store that
        // must not be accepted.
        txn(1'b0, 32'h20, 32'h0, 1'b1, lat, rd, er);
        e = pop_exp();
        n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL bp_rdata: got %h want %h", rd, e.rdata); end
        req_write = 1'b1; req_wdata = 32'h00000BAD;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall_%0d: got valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0",
                         i, resp_valid, resp_rdata, resp_err, req_ready, e.rdata, e.err);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        done_exp   = done_exp + 16'd1;
        n_checks++; if (done_count !== done_exp) begin n_fail++; $display("FAIL bp_done_count: got %0d want %0d", done_count, done_exp); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (resp_valid !== 1'b0 || done_count !== done_exp) begin n_fail++; $display("FAIL bp_single_resp: got valid=%b count=%0d want 0/%0d", resp_valid, done_count, done_exp); end
        txn(1'b0, 32'h20, 32'h0, 1'b0, lat, rd, er);
        e = pop_exp();
        n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL bp_no_stray_store: got %h want %h", rd, e.rdata); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er; exp_t e; logic [31:0] saved;
        txn(1'b1, 32'h10, 32'hAA, 1'b0, lat, rd, er);
        e = pop_exp();
        handshake();
        saved = model_mem[4];
        // Accept a store, then reset while it sits in WAIT.
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_in_wait: got ready=%b want 0", req_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        done_exp = 16'd0;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_idle: got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
        n_checks++; if (done_count !== 16'd0) begin n_fail++; $display("FAIL rm_done_count: got %0d want 0", done_count); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_resp: got %b want 0", resp_valid); end
        model_mem[4] = saved;
        txn(1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er);
        e = pop_exp();
        n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL rm_load_old: got %h want %h", rd, e.rdata); end
        handshake();
        n_checks++; if (done_count !== done_exp) begin n_fail++; $display("FAIL rm_count_after: got %0d want %0d", done_count, done_exp); end
    endtask

    // LATENCY=1: continuous back-to-back traffic, 65536 responses to wrap.
    task automatic test_latency1_wrap();
        int n_acc, n_resp, last_acc, k;
        logic [31:0] last_data;
        exp_t e;
        n_acc = 0; n_resp = 0; last_acc = -100; last_data = 32'd0;
        @(negedge clk1);
        reset1 = 1'b0;
        resp_ready1 = 1'b1;
        for (int cyc = 0; cyc < 140000 && n_resp < 65536; cyc++) begin
            @(negedge clk1);
            if (resp_valid1) begin
                e.rdata = 'x; e.err = 1'bx;
                if (sb1.size() > 0) e = sb1.pop_front();
                if (n_resp < 16 || n_resp >= 65530) begin
                    n_checks++;
                    if (resp_rdata1 !== e.rdata || resp_err1 !== e.err || (cyc - last_acc) != 1) begin
                        n_fail++;
                        $display("FAIL l1_resp_%0d: got rdata=%h err=%b lat=%0d want %h/%b/1",
                                 n_resp, resp_rdata1, resp_err1, cyc - last_acc, e.rdata, e.err);
                    end
                end
                if (n_resp < 4 || n_resp == 65535) begin
                    n_checks++;
                    if (done_count1 !== n_resp[15:0]) begin n_fail++; $display("FAIL l1_count_%0d: got %h want %h", n_resp, done_count1, n_resp[15:0]); end
                end
                n_resp++;
            end else if (req_ready1) begin
                if (n_acc > 0 && n_acc < 16) begin
                    n_checks++;
                    if ((cyc - last_acc) != 2) begin n_fail++; $display("FAIL l1_spacing_%0d: got %0d want 2", n_acc, cyc - last_acc); end
                end
                if (n_acc < 65536) begin
                    k = (n_acc >> 1);
                    req_addr1  = {24'd0, 6'(k % 64), 2'b00};
                    req_valid1 = 1'b1;
                    if ((n_acc % 2) == 0) begin
                        req_write1 = 1'b1;
                        req_wdata1 = {16'hA5A5, 16'(k)};
                        last_data  = req_wdata1;
                        sb1.push_back('{rdata: 32'd0, err: 1'b0});
                    end else begin
                        req_write1 = 1'b0;
                        sb1.push_back('{rdata: last_data, err: 1'b0});
                    end
                    last_acc = cyc;
                    n_acc++;
                end else begin
                    req_valid1 = 1'b0;
                end
            end
        end
        req_valid1 = 1'b0;
        n_checks++; if (n_resp != 65536) begin n_fail++; $display("FAIL l1_timeout: got %0d responses want 65536", n_resp); end
        @(negedge clk1);
        n_checks++; if (done_count1 !== 16'd0) begin n_fail++; $display("FAIL l1_wrap: got %h want 0000", done_count1); end
        n_checks++; if (resp_valid1 !== 1'b0) begin n_fail++; $display("FAIL l1_idle_end: got %b want 0", resp_valid1); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misalign();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_latency1_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Parameters
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to response valid; legal range 1..15.

Interface
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store (STR), 0 = load (LDR).
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 SHALL have port resp_valid, output, 1 bit: response available.
REQ-011 SHALL have port resp_ready, input, 1 bit: initiator consumes the response.
REQ-012 SHALL have port resp_rdata, output, 32 bits: load data (0 for stores and errors).
REQ-013 SHALL have port resp_err, output, 1 bit: access fault.
REQ-014 SHALL have port done_count, output, 16 bits: number of completed responses.

Function
REQ-015 SHALL implement states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, and resp_valid SHALL be 1 only in RESP.
REQ-016 SHALL accept a request on an edge where req_valid & req_ready, registering req_write, req_addr and req_wdata; request inputs SHALL be ignored outside IDLE.
REQ-017 On accept, SHALL go to RESP if LATENCY==1; otherwise it SHALL go to WAIT and load the wait counter with LATENCY-2.
REQ-018 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0, so resp_valid rises exactly LATENCY edges after the accept edge.
REQ-019 Fault condition: captured addr[1:0] != 0, or addr[31:2] >= DEPTH.
REQ-020 On the edge entering RESP, a non-faulting store SHALL write wdata to word addr[31:2]; a non-faulting load SHALL register that word into resp_rdata; a fault SHALL set resp_err=1, resp_rdata=0, and leave storage unchanged.
REQ-021 Storage SHALL be modified only at the commit edge of REQ-020 and never at any other time.
REQ-022 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1; on that edge it SHALL go to IDLE, clear resp_valid, resp_rdata and resp_err, and increment done_count.
REQ-023 No request SHALL be accepted on the response-handshake edge; the minimum spacing between accepts is LATENCY+1 cycles.
REQ-024 done_count SHALL wrap from 0xFFFF to 0x0000; it SHALL count faulting responses as well.
REQ-025 A load SHALL return the most recently committed store to the same word.

Reset
REQ-026 When reset=1 at a rising edge, SHALL enter IDLE and set req_ready=1 (combinational from IDLE), resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0, done_count=0.
REQ-027 Reset SHALL take priority over every other event; a request in WAIT SHALL be abandoned, and its store SHALL NOT be committed.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-029 Bench SHALL cover store/load with LATENCY=2: store 0x00000007 to 0x64, then load 0x64 -> resp_valid exactly 2 edges after each accept, load resp_rdata=0x00000007, resp_err=0, done_count=2.
REQ-030 Bench SHALL cover misalignment: store 0xDEADBEEF to 0x62 -> resp_err=1, resp_rdata=0; a following load of 0x60 returns its prior value unchanged.
REQ-031 Bench SHALL cover out of range: load 0x100 with DEPTH=64 -> resp_err=1, resp_rdata=0, done_count increments.
REQ-032 Bench SHALL cover backpressure: hold resp_ready=0 for 5 cycles in RESP while req_valid=1 -> resp_* stable, req_ready=0, no second accept; a single response completes when resp_ready=1.
REQ-033 Bench SHALL cover reset mid-operation: accept a store of 0x55 to 0x10, assert reset in WAIT -> IDLE, resp_valid=0, done_count=0; a subsequent load of 0x10 returns the old value, not 0x55.
REQ-034 Bench SHALL cover LATENCY=1 and counter wrap: back-to-back handshakes give accepts 2 cycles apart; preloading done_count via 65536 responses gives a wrap to 0.
